mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates one single-port synchronous RAM between three requesters:
  - VGA scanout fetch (real-time, highest priority).
  - CPU instruction fetch.
  - CPU data load/store.
- Sits between the CPU control/datapath, the VGA pixel pipeline and the shared RAM macro.
- Issues at most one RAM access per cycle and routes read data back to the requester that issued it.

Parameters:
- ADDR_W, 16, word address width.
- DATA_W, 16, data word width.
- RAM_LAT, 1, RAM read latency in cycles from ram_en to valid ram_rdata; legal range 1..4.
- STARVE_MAX, 8, maximum consecutive VGA grants while any CPU request is pending; legal range 1..255.

Ports:
- clk  in  1  clock
- rst_async  in  1  asynchronous active-high reset
- vga_req  in  1  VGA read request
- vga_addr  in  ADDR_W  VGA read address
- vga_gnt  out  1  VGA request accepted this cycle
- vga_rvalid  out  1  rdata valid for VGA
- if_req  in  1  CPU instruction fetch request (read only)
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  rdata valid for fetch
- d_req  in  1  CPU data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  rdata valid for data read
- rdata  out  DATA_W  shared read-data return bus
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset (rst_async high):
  - Registered outputs cleared immediately: ram_en, ram_we, ram_addr, ram_wdata, all *_rvalid.
  - Starvation counter cleared; round-robin pointer set to IF_NEXT.
  - Read-tag pipeline flushed.
  - All *_gnt forced 0 while reset is asserted.
- Handshake:
  - Requester asserts req and holds addr/we/wdata stable until it samples gnt=1 at a rising edge.
  - gnt is combinational from req and arbiter state.
  - A request is consumed on the clock edge where req && gnt.
  - Requester may drop req before grant without side effects.
- Grant selection, one winner per cycle:
  1. If vga_req and (starve_cnt < STARVE_MAX or no CPU req pending): grant VGA.
  2. Otherwise grant a CPU requester via round-robin between if and d.
     - Pointer states IF_NEXT / D_NEXT.
     - If only one CPU requester is asserted, it wins regardless of pointer.
     - After a CPU grant, the pointer moves to the other requester.
     - With no CPU grant, the pointer holds.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each VGA grant while if_req || d_req.
  - Clears on any CPU grant, and on any cycle with no CPU request pending.
- RAM issue:
  - On the grant edge, ram_en/ram_we/ram_addr/ram_wdata are registered from the winner.
  - ram_we=1 only for a d_we=1 grant; ram_wdata is don't-care otherwise.
  - ram_en=0 in cycles following no grant.
- Read return:
  - Tag (VGA/IF/D/none) is shifted through a RAM_LAT-deep pipeline alongside ram_en.
  - rdata = ram_rdata, passed combinationally.
  - Exactly one *_rvalid is high in the cycle the tag emerges.
  - Writes carry tag none, so no rvalid.
  - Read latency: gnt edge to rvalid = 1 + RAM_LAT cycles.
- Throughput and ordering:
  - Back-to-back grants to the same requester are allowed.
  - Full throughput is one access per cycle.
  - Responses return in grant order.
- Reset mid-operation: in-flight reads are discarded; no rvalid is produced after reset deasserts for pre-reset grants.
- Simultaneous events: all three requesting with starve_cnt < STARVE_MAX -> VGA wins; the CPU pointer is unchanged.

Optional Feature:
- Macro MEM_ARBITER_STATS_EN.
- Defined:
  - Adds output stat_vga_grants (16 bit): count of VGA grants.
  - Adds output stat_cpu_stall (16 bit): count of cycles with (if_req || d_req) and neither if_gnt nor d_gnt.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Single read, RAM_LAT=1: d_req=1, d_we=0, d_addr=16'h0040, RAM holds 16'hBEEF -> d_gnt same cycle; ram_en/ram_addr=16'h0040 next cycle; d_rvalid=1 with rdata=16'hBEEF two cycles after grant; no other rvalid.
2. Write then read: d write 16'h1234 to 16'h0010, then d read 16'h0010 -> ram_we=1 one cycle only, no d_rvalid for the write; the read returns 16'h1234.
3. Round-robin: if_req and d_req held for 6 cycles, no VGA -> grants alternate IF, D, IF, D, IF, D starting from IF after reset.
4. Starvation, STARVE_MAX=8: vga_req and if_req held continuously -> 8 VGA grants, then 1 IF grant, then 8 VGA; rvalids match grant order.
5. Reset mid-flight, RAM_LAT=3: grant VGA read, assert rst_async on the next cycle for one cycle -> no vga_rvalid afterwards; all *_gnt=0 during reset; ram_en=0.
6. MEM_ARBITER_STATS_EN defined: run test 4 for 18 cycles -> stat_vga_grants=16, stat_cpu_stall=16.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signal bundle for mem_arbiter.
// Stat signals exist only with MEM_ARBITER_STATS_EN defined.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
`ifdef MEM_ARBITER_STATS_EN
  logic [15:0]       stat_vga_grants;
  logic [15:0]       stat_cpu_stall;
`endif

  modport slave (
`ifdef MEM_ARBITER_STATS_EN
    output stat_vga_grants, stat_cpu_stall,
`endif
    input  vga_req, vga_addr,
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  ram_rdata,
    output vga_gnt, vga_rvalid,
    output if_gnt, if_rvalid,
    output d_gnt, d_rvalid, rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
`ifdef MEM_ARBITER_STATS_EN
    input  stat_vga_grants, stat_cpu_stall,
`endif
    output vga_req, vga_addr,
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output ram_rdata,
    input  vga_gnt, vga_rvalid,
    input  if_gnt, if_rvalid,
    input  d_gnt, d_rvalid, rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shared-RAM arbiter: VGA priority with starvation cap, IF/D round-robin.
// Define MEM_ARBITER_STATS_EN to add grant/stall counters.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_async,
  mem_arbiter_if.slave  bus
);
  typedef enum logic {IF_NEXT, D_NEXT} rr_e;
  typedef enum logic [1:0] {
    TAG_NONE, TAG_VGA, TAG_IF, TAG_D
  } tag_e;

  localparam logic [7:0] SMAX = 8'(STARVE_MAX);

  rr_e               ptr_q, ptr_d;
  logic [7:0]        starve_q, starve_d;
  logic              cpu_pend;
  logic              vga_win, if_win, d_win;
  tag_e              tag_d;
  tag_e              tag_q [RAM_LAT+1];
  logic              ram_en_q, ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q;

  always_comb begin
    cpu_pend = bus.if_req | bus.d_req;
    vga_win  = !rst_async && bus.vga_req &&
               (starve_q < SMAX || !cpu_pend);
    if_win   = !rst_async && !vga_win && bus.if_req &&
               (!bus.d_req || ptr_q == IF_NEXT);
    d_win    = !rst_async && !vga_win && bus.d_req &&
               (!bus.if_req || ptr_q == D_NEXT);
  end

  always_comb begin
    ptr_d      = ptr_q;
    starve_d   = starve_q;
    tag_d      = TAG_NONE;
    ram_addr_d = ram_addr_q;
    unique case (1'b1)
      vga_win: begin
        tag_d      = TAG_VGA;
        ram_addr_d = bus.vga_addr;
      end
      if_win: begin
        tag_d      = TAG_IF;
        ram_addr_d = bus.if_addr;
        ptr_d      = D_NEXT;
      end
      d_win: begin
        tag_d      = bus.d_we ? TAG_NONE : TAG_D;
        ram_addr_d = bus.d_addr;
        ptr_d      = IF_NEXT;
      end
      default: ;
    endcase
    // VGA may only hold CPU off for SMAX consecutive grants
    if (if_win || d_win || !cpu_pend)
      starve_d = 8'd0;
    else if (vga_win && starve_q < SMAX)
      starve_d = starve_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      ptr_q       <= IF_NEXT;
      starve_q    <= 8'd0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      for (int i = 0; i <= RAM_LAT; i++)
        tag_q[i] <= TAG_NONE;
    end else begin
      ptr_q      <= ptr_d;
      starve_q   <= starve_d;
      ram_en_q   <= vga_win | if_win | d_win;
      ram_we_q   <= d_win & bus.d_we;
      ram_addr_q <= ram_addr_d;
      if (d_win)
        ram_wdata_q <= bus.d_wdata;
      tag_q[0] <= tag_d;
      for (int i = 1; i <= RAM_LAT; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  assign bus.vga_gnt    = vga_win;
  assign bus.if_gnt     = if_win;
  assign bus.d_gnt      = d_win;
  assign bus.vga_rvalid = tag_q[RAM_LAT] == TAG_VGA;
  assign bus.if_rvalid  = tag_q[RAM_LAT] == TAG_IF;
  assign bus.d_rvalid   = tag_q[RAM_LAT] == TAG_D;
  assign bus.rdata      = bus.ram_rdata;
  assign bus.ram_en     = ram_en_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;

`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] vcnt_q, scnt_q;
  logic        stall;

  assign stall = cpu_pend && !if_win && !d_win;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      vcnt_q <= 16'd0;
      scnt_q <= 16'd0;
    end else begin
      if (vga_win && vcnt_q != 16'hFFFF)
        vcnt_q <= vcnt_q + 16'd1;
      if (stall && scnt_q != 16'hFFFF)
        scnt_q <= scnt_q + 16'd1;
    end
  end

  assign bus.stat_vga_grants = vcnt_q;
  assign bus.stat_cpu_stall  = scnt_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized scoreboard.
module tb_mem_arbiter;
  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int RAM_LAT = 1;
  localparam int SMAX    = 8;

  typedef struct {
    logic [2:0]  who;
    logic [15:0] data;
    int          due;
  } resp_t;

  logic clk = 1'b0;
  logic rst_async;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .RAM_LAT(RAM_LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .rst_async(rst_async),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: RAM_LAT edges from ram_en to data
  logic [15:0] mem [256];
  logic [15:0] rd_pipe [RAM_LAT];
  logic        pl_en;
  logic [7:0]  pl_a;
  logic [15:0] pl_d;

  always @(posedge clk) begin
    if (pl_en)
      mem[pl_a] <= pl_d;
    else if (bus.ram_en && bus.ram_we)
      mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
    rd_pipe[0] <= (bus.ram_en && !bus.ram_we) ?
                  mem[bus.ram_addr[7:0]] : 16'h0;
    for (int i = 1; i < RAM_LAT; i++)
      rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.ram_rdata = rd_pipe[RAM_LAT-1];

  task automatic clear_inputs();
    bus.vga_req  = 0; bus.vga_addr = '0;
    bus.if_req   = 0; bus.if_addr  = '0;
    bus.d_req    = 0; bus.d_we     = 0;
    bus.d_addr   = '0; bus.d_wdata = '0;
  endtask

  task automatic do_reset();
    rst_async = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_async = 0;
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_en = 1; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_en = 0;
  endtask

  task automatic test_reset();
    rst_async = 1;
    bus.vga_req = 1; bus.if_req = 1; bus.d_req = 1;
    #1;
    n_chk++;
    if ({bus.vga_gnt, bus.if_gnt, bus.d_gnt} !== 3'b000)
      $display("FAIL rst_gnt: got %b want 000",
        {bus.vga_gnt, bus.if_gnt, bus.d_gnt});
    else n_pass++;
    n_chk++;
    if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== 34'h0)
      $display("FAIL rst_ram: got %b %b %h %h want 0 0 0 0",
        bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if ({bus.vga_rvalid, bus.if_rvalid, bus.d_rvalid,
         bus.vga_gnt, bus.if_gnt, bus.d_gnt, bus.ram_en} !== 7'b0)
      $display("FAIL rst_hold: got %b want 0",
        {bus.vga_rvalid, bus.if_rvalid, bus.d_rvalid,
         bus.vga_gnt, bus.if_gnt, bus.d_gnt, bus.ram_en});
    else n_pass++;
`ifdef MEM_ARBITER_STATS_EN
    n_chk++;
    if ({bus.stat_vga_grants, bus.stat_cpu_stall} !== 32'h0)
      $display("FAIL rst_stats: got %h %h want 0 0",
        bus.stat_vga_grants, bus.stat_cpu_stall);
    else n_pass++;
`endif
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    preload(8'h40, 16'hBEEF);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0040;
    @(negedge clk);
    n_chk++;
    if ({bus.vga_gnt, bus.if_gnt, bus.d_gnt} !== 3'b001)
      $display("FAIL rd_gnt: got %b want 001",
        {bus.vga_gnt, bus.if_gnt, bus.d_gnt});
    else n_pass++;
    @(posedge clk); #1;
    bus.d_req = 0;
    for (int k = 1; k <= RAM_LAT + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_chk++;
        if ({bus.ram_en, bus.ram_we, bus.ram_addr} !== {2'b10, 16'h0040})
          $display("FAIL rd_ram: got %b %b %h want 1 0 0040",
            bus.ram_en, bus.ram_we, bus.ram_addr);
        else n_pass++;
      end
      if (k == RAM_LAT + 1) begin
        n_chk++;
        if ({bus.vga_rvalid, bus.if_rvalid, bus.d_rvalid} !== 3'b001 ||
            bus.rdata !== 16'hBEEF)
          $display("FAIL rd_ret: got %b %h want 001 beef",
            {bus.vga_rvalid, bus.if_rvalid, bus.d_rvalid}, bus.rdata);
        else n_pass++;
      end else begin
        n_chk++;
        if ({bus.vga_rvalid, bus.if_rvalid, bus.d_rvalid} !== 3'b000)
          $display("FAIL rd_idle%0d: got %b want 000", k,
            {bus.vga_rvalid, bus.if_rvalid, bus.d_rvalid});
        else n_pass++;
      end
    end
  endtask

  task automatic test_write_read();
    do_reset();
    bus.d_req = 1; bus.d_we = 1;
    bus.d_addr = 16'h0010; bus.d_wdata = 16'h1234;
    @(negedge clk);
    n_chk++;
    if ({bus.vga_gnt, bus.if_gnt, bus.d_gnt} !== 3'b001)
      $display("FAIL wr_gnt: got %b want 001",
        {bus.vga_gnt, bus.if_gnt, bus.d_gnt});
    else n_pass++;
    @(posedge clk); #1;
    bus.d_we = 0;
    @(negedge clk);
    n_chk++;
    if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata} !==
        {2'b11, 16'h0010, 16'h1234} || bus.d_gnt !== 1'b1)
      $display("FAIL wr_ram: got %b %b %h %h g%b want 1 1 0010 1234 g1",
        bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.d_gnt);
    else n_pass++;
    @(posedge clk); #1;
    bus.d_req = 0;
    for (int k = 1; k <= RAM_LAT + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_chk++;
        if ({bus.ram_en, bus.ram_we} !== 2'b10)
          $display("FAIL wr_once: got %b%b want 10", bus.ram_en, bus.ram_we);
        else n_pass++;
      end
      if (k == RAM_LAT + 1) begin
        n_chk++;
        if ({bus.vga_rvalid, bus.if_rvalid, bus.d_rvalid} !== 3'b001 ||
            bus.rdata !== 16'h1234)
          $display("FAIL wr_rd: got %b %h want 001 1234",
            {bus.vga_rvalid, bus.if_rvalid, bus.d_rvalid}, bus.rdata);
        else n_pass++;
      end else begin
        n_chk++;
        if ({bus.vga_rvalid, bus.if_rvalid, bus.d_rvalid} !== 3'b000)
          $display("FAIL wr_norv%0d: got %b want 000", k,
            {bus.vga_rvalid, bus.if_rvalid, bus.d_rvalid});
        else n_pass++;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp;
    do_reset();
    bus.if_req = 1; bus.d_req = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp = (i % 2 == 0) ? 3'b010 : 3'b001;
      n_chk++;
      if ({bus.vga_gnt, bus.if_gnt, bus.d_gnt} !== exp)
        $display("FAIL rr%0d: got %b want %b", i,
          {bus.vga_gnt, bus.if_gnt, bus.d_gnt}, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
    clear_inputs();
    repeat (RAM_LAT + 2) @(posedge clk);
    #1;
  endtask

  task automatic test_starvation();
    logic [2:0] g [18];
    logic [2:0] exp;
    int         j;
    for (int i = 0; i < 18; i++)
      g[i] = (i % (SMAX + 1) == SMAX) ? 3'b010 : 3'b100;
    do_reset();
    for (int i = 0; i < 18 + RAM_LAT + 2; i++) begin
      bus.vga_req = (i < 18); bus.if_req = (i < 18);
      bus.vga_addr = 16'(i); bus.if_addr = 16'(i + 32);
      @(negedge clk);
      if (i < 18) begin
        n_chk++;
        if ({bus.vga_gnt, bus.if_gnt, bus.d_gnt} !== g[i])
          $display("FAIL starve_g%0d: got %b want %b", i,
            {bus.vga_gnt, bus.if_gnt, bus.d_gnt}, g[i]);
        else n_pass++;
      end
      j = i - 1 - RAM_LAT;
      exp = (j >= 0 && j < 18) ? g[j] : 3'b000;
      n_chk++;
      if ({bus.vga_rvalid, bus.if_rvalid, bus.d_rvalid} !== exp)
        $display("FAIL starve_rv%0d: got %b want %b", i,
          {bus.vga_rvalid, bus.if_rvalid, bus.d_rvalid}, exp);
      else n_pass++;
`ifdef MEM_ARBITER_STATS_EN
      if (i == 18) begin
        n_chk++;
        if (bus.stat_vga_grants !== 16'd16 || bus.stat_cpu_stall !== 16'd16)
          $display("FAIL stats: got %0d %0d want 16 16",
            bus.stat_vga_grants, bus.stat_cpu_stall);
        else n_pass++;
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.vga_req = 1; bus.vga_addr = 16'h0005;
    @(negedge clk);
    n_chk++;
    if (bus.vga_gnt !== 1'b1)
      $display("FAIL mf_gnt: got %b want 1", bus.vga_gnt);
    else n_pass++;
    @(posedge clk); #1;
    rst_async = 1;
    bus.if_req = 1; bus.d_req = 1;
    @(negedge clk);
    n_chk++;
    if ({bus.vga_gnt, bus.if_gnt, bus.d_gnt, bus.ram_en} !== 4'b0)
      $display("FAIL mf_rst: got %b want 0000",
        {bus.vga_gnt, bus.if_gnt, bus.d_gnt, bus.ram_en});
    else n_pass++;
    @(posedge clk); #1;
    rst_async = 0;
    clear_inputs();
    for (int k = 0; k < RAM_LAT + 3; k++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.vga_rvalid, bus.if_rvalid, bus.d_rvalid} !== 3'b000)
        $display("FAIL mf_rv%0d: got %b want 000", k,
          {bus.vga_rvalid, bus.if_rvalid, bus.d_rvalid});
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int n);
    logic        vp, ip, dp, dwe, cpu;
    logic [15:0] va, ia, da, dw;
    int          starve;
    bit          if_next;
    logic [2:0]  g, rv_exp;
    logic [15:0] d_exp;
    logic        pen, pwe;
    logic [15:0] pa, pwd;
    resp_t       q[$];
    logic [15:0] sh [256];
    do_reset();
    starve = 0; if_next = 1; pen = 0; pwe = 0; pa = '0; pwd = '0;
    vp = 0; ip = 0; dp = 0; dwe = 0;
    va = '0; ia = '0; da = '0; dw = '0;
    for (int k = 0; k < 256; k++) begin
      sh[k] = 16'($urandom);
      preload(8'(k), sh[k]);
    end
    for (int i = 0; i < n + 20; i++) begin
      bus.vga_req = vp; bus.vga_addr = va;
      bus.if_req = ip; bus.if_addr = ia;
      bus.d_req = dp; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dw;
      @(negedge clk);
      cpu = ip || dp;
      if (vp && (starve < SMAX || !cpu)) g = 3'b100;
      else if (ip && (!dp || if_next))   g = 3'b010;
      else if (dp)                       g = 3'b001;
      else                               g = 3'b000;
      n_chk++;
      if ({bus.vga_gnt, bus.if_gnt, bus.d_gnt} !== g)
        $display("FAIL rnd_gnt@%0d: got %b want %b", cyc,
          {bus.vga_gnt, bus.if_gnt, bus.d_gnt}, g);
      else n_pass++;
      n_chk++;
      if (bus.ram_en !== pen ||
          (pen && (bus.ram_we !== pwe || bus.ram_addr !== pa)) ||
          (pen && pwe && bus.ram_wdata !== pwd))
        $display("FAIL rnd_ram@%0d: got %b %b %h %h want %b %b %h %h",
          cyc, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata,
          pen, pwe, pa, pwd);
      else n_pass++;
      rv_exp = 3'b000; d_exp = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        rv_exp = q[0].who; d_exp = q[0].data;
        void'(q.pop_front());
      end
      n_chk++;
      if ({bus.vga_rvalid, bus.if_rvalid, bus.d_rvalid} !== rv_exp ||
          (rv_exp != 3'b000 && bus.rdata !== d_exp))
        $display("FAIL rnd_rv@%0d: got %b %h want %b %h", cyc,
          {bus.vga_rvalid, bus.if_rvalid, bus.d_rvalid}, bus.rdata,
          rv_exp, d_exp);
      else n_pass++;
      pen = (g != 3'b000);
      pwe = 0;
      if (g[2]) begin
        pa = va; vp = 0;
        q.push_back('{3'b100, sh[va[7:0]], cyc + 1 + RAM_LAT});
      end
      if (g[1]) begin
        pa = ia; ip = 0; if_next = 0;
        q.push_back('{3'b010, sh[ia[7:0]], cyc + 1 + RAM_LAT});
      end
      if (g[0]) begin
        pa = da; pwe = dwe; pwd = dw; dp = 0; if_next = 1;
        if (dwe) sh[da[7:0]] = dw;
        else q.push_back('{3'b001, sh[da[7:0]], cyc + 1 + RAM_LAT});
      end
      if (g[1] || g[0] || !cpu) starve = 0;
      else if (g[2] && starve < SMAX) starve++;
      @(posedge clk); #1;
      if (i < n) begin
        if (!vp && $urandom_range(0, 3) != 0) begin
          vp = 1; va = {8'h0, 8'($urandom)};
        end else if (vp && $urandom_range(0, 15) == 0) vp = 0;
        if (!ip && $urandom_range(0, 1) == 0) begin
          ip = 1; ia = {8'h0, 8'($urandom)};
        end else if (ip && $urandom_range(0, 15) == 0) ip = 0;
        if (!dp && $urandom_range(0, 1) == 0) begin
          dp = 1; da = {8'h0, 8'($urandom)};
          dwe = 1'($urandom); dw = 16'($urandom);
        end else if (dp && $urandom_range(0, 15) == 0) dp = 0;
      end else begin
        vp = 0; ip = 0; dp = 0;
      end
    end
    n_chk++;
    if (q.size() != 0)
      $display("FAIL rnd_drain: got %0d pending want 0", q.size());
    else n_pass++;
  endtask

  initial begin
    pl_en = 0; pl_a = '0; pl_d = '0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_write_read();
    test_round_robin();
    test_starvation();
    test_reset_midflight();
    test_random(1500);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
